// File: rtl/fib_index.sv
// Fibonacci index search: returns the largest n with fib(n) <= value,
// plus exact-match and overflow flags, by stepping the sequence one term per cycle.
module fib_index #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_x,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_in_value,
  output logic             o_in_ready,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [IDXW-1:0]  o_out_index,
  output logic             o_out_exact,
  output logic             o_out_ovf
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           r_state, w_state_nx;
  logic             r_in_ready, r_out_valid;
  logic [WIDTH-1:0] r_v, r_a;
  logic [WIDTH:0]   r_b;
  logic [IDXW-1:0]  r_n;
  logic [IDXW-1:0]  r_index;
  logic             r_exact, r_ovf;

  logic w_accept, w_hit, w_over, w_ovf, w_consume;

  assign w_accept  = (r_state == S_IDLE) && i_in_valid && r_in_ready;
  assign w_hit     = (r_a == r_v);
  assign w_over    = (r_a > r_v);
  // A is still below V but the next term no longer fits in WIDTH bits
  assign w_ovf     = r_b[WIDTH];
  assign w_consume = (r_state == S_DONE) && r_out_valid && i_out_ready;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nx = S_SEARCH;
      S_SEARCH: if (w_hit || w_over || w_ovf) w_state_nx = S_DONE;
      S_DONE:   if (w_consume) w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_in_ready  <= (w_state_nx == S_IDLE);
      r_out_valid <= (w_state_nx == S_DONE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      r_v     <= '0;
      r_a     <= '0;
      r_b     <= {{WIDTH{1'b0}}, 1'b1};
      r_n     <= '0;
      r_index <= '0;
      r_exact <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_v <= i_in_value;
        r_a <= '0;
        r_b <= {{WIDTH{1'b0}}, 1'b1};
        r_n <= '0;
      end else if (r_state == S_SEARCH) begin
        if (w_hit) begin
          r_index <= r_n;
          r_exact <= 1'b1;
          r_ovf   <= 1'b0;
        end else if (w_over) begin
          r_index <= r_n - {{(IDXW-1){1'b0}}, 1'b1};
          r_exact <= 1'b0;
          r_ovf   <= 1'b0;
        end else if (w_ovf) begin
          r_index <= r_n;
          r_exact <= 1'b0;
          r_ovf   <= 1'b1;
        end else begin
          r_a <= r_b[WIDTH-1:0];
          r_b <= {1'b0, r_a} + r_b;
          r_n <= r_n + {{(IDXW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_index = r_index;
  assign o_out_exact = r_exact;
  assign o_out_ovf   = r_ovf;

endmodule

// File: tb/tb_fib_index.sv
// Directed bench for fib_index: vector table of searches plus hand-written
// sequences for back-pressure, ignored requests and mid-search reset.
module tb_fib_index;

  logic        i_clk = 1'b0;
  logic        i_rst_x;
  logic        i_in_valid;
  logic [31:0] i_in_value;
  logic        o_in_ready;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [7:0]  o_out_index;
  logic        o_out_exact;
  logic        o_out_ovf;

  int n_checks = 0;
  int n_errors = 0;

  fib_index #(.WIDTH(32), .IDXW(8)) dut (
    .i_clk       (i_clk),
    .i_rst_x     (i_rst_x),
    .i_in_valid  (i_in_valid),
    .i_in_value  (i_in_value),
    .o_in_ready  (o_in_ready),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_index (o_out_index),
    .o_out_exact (o_out_exact),
    .o_out_ovf   (o_out_ovf)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] value;
    logic [7:0]  idx;
    logic        exact;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int cyc = 0;
    while (!o_in_ready && cyc < 50) begin
      @(posedge i_clk); #1; cyc++;
    end
    chk("in_ready before request", {63'd0, o_in_ready}, 64'd1);
  endtask

  // Issue one request; returns edges from E0 until o_out_valid (capped at 200).
  task automatic issue(input logic [31:0] v, output int lat);
    int cyc;
    i_in_valid = 1'b1;
    i_in_value = v;
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    i_in_value = ~v;
    cyc = 0;
    while (!o_out_valid && cyc < 200) begin
      @(posedge i_clk); #1; cyc++;
    end
    lat = cyc;
  endtask

  task automatic consume(input logic [7:0] idx, input logic exact, input logic ovf);
    i_out_ready = 1'b1;
    @(posedge i_clk); #1;
    i_out_ready = 1'b0;
    chk("out_valid after consume", {63'd0, o_out_valid}, 64'd0);
    chk("in_ready after consume", {63'd0, o_in_ready}, 64'd1);
    chk("index kept after consume", {56'd0, o_out_index}, {56'd0, idx});
    chk("exact/ovf kept after consume", {62'd0, o_out_exact, o_out_ovf}, {62'd0, exact, ovf});
  endtask

  initial begin
    int lat;
    logic [7:0] held_idx;

    vecs[0] = '{32'd0,          8'd0,  1'b1, 1'b0, 1};
    vecs[1] = '{32'd1,          8'd1,  1'b1, 1'b0, 2};
    vecs[2] = '{32'd2,          8'd3,  1'b1, 1'b0, 4};
    vecs[3] = '{32'd3,          8'd4,  1'b1, 1'b0, 5};
    vecs[4] = '{32'd4,          8'd4,  1'b0, 1'b0, 6};
    vecs[5] = '{32'd8,          8'd6,  1'b1, 1'b0, 7};
    vecs[6] = '{32'd100,        8'd11, 1'b0, 1'b0, 13};
    vecs[7] = '{32'd4181,       8'd19, 1'b1, 1'b0, 20};
    vecs[8] = '{32'd2971215073, 8'd47, 1'b1, 1'b0, 48};
    vecs[9] = '{32'hFFFFFFFF,   8'd47, 1'b0, 1'b1, 48};

    i_rst_x     = 1'b0;
    i_in_valid  = 1'b0;
    i_in_value  = '0;
    i_out_ready = 1'b0;
    #3;
    chk("reset in_ready", {63'd0, o_in_ready}, 64'd0);
    chk("reset out_valid", {63'd0, o_out_valid}, 64'd0);
    chk("reset result", {54'd0, o_out_index, o_out_exact, o_out_ovf}, 64'd0);
    @(posedge i_clk); #1;
    chk("in_ready held in reset", {63'd0, o_in_ready}, 64'd0);
    @(negedge i_clk);
    i_rst_x = 1'b1;
    @(posedge i_clk); #1;
    chk("in_ready first edge after reset", {63'd0, o_in_ready}, 64'd1);

    for (int i = 0; i < 10; i++) begin
      wait_ready();
      issue(vecs[i].value, lat);
      chk($sformatf("latency v=%0d", vecs[i].value), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("index v=%0d", vecs[i].value), {56'd0, o_out_index}, {56'd0, vecs[i].idx});
      chk($sformatf("exact v=%0d", vecs[i].value), {63'd0, o_out_exact}, {63'd0, vecs[i].exact});
      chk($sformatf("ovf v=%0d", vecs[i].value), {63'd0, o_out_ovf}, {63'd0, vecs[i].ovf});
      consume(vecs[i].idx, vecs[i].exact, vecs[i].ovf);
    end

    // Back-pressure: result held for 10 cycles while stray requests arrive.
    wait_ready();
    issue(32'd100, lat);
    chk("bp latency", 64'(lat), 64'd13);
    for (int c = 0; c < 10; c++) begin
      i_in_valid = c[0];
      i_in_value = 32'd5;
      @(posedge i_clk); #1;
      chk("bp out_valid", {63'd0, o_out_valid}, 64'd1);
      chk("bp in_ready", {63'd0, o_in_ready}, 64'd0);
      chk("bp index", {56'd0, o_out_index}, 64'd11);
      chk("bp exact/ovf", {62'd0, o_out_exact, o_out_ovf}, 64'd0);
    end
    // Request present on the consume edge must not be taken.
    i_in_valid  = 1'b1;
    i_out_ready = 1'b1;
    @(posedge i_clk); #1;
    i_in_valid  = 1'b0;
    i_out_ready = 1'b0;
    chk("no bypass in_ready", {63'd0, o_in_ready}, 64'd1);
    chk("no bypass out_valid", {63'd0, o_out_valid}, 64'd0);
    @(posedge i_clk); #1;
    chk("idle stays idle", {63'd0, o_in_ready}, 64'd1);

    // Reset in the middle of a search.
    i_in_valid = 1'b1;
    i_in_value = 32'd4181;
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    chk("search in_ready low", {63'd0, o_in_ready}, 64'd0);
    repeat (5) @(posedge i_clk);
    #2;
    i_rst_x = 1'b0;
    #1;
    chk("midreset in_ready", {63'd0, o_in_ready}, 64'd0);
    chk("midreset out_valid", {63'd0, o_out_valid}, 64'd0);
    chk("midreset result", {54'd0, o_out_index, o_out_exact, o_out_ovf}, 64'd0);
    @(negedge i_clk);
    i_rst_x = 1'b1;
    held_idx = 8'd0;
    for (int c = 0; c < 30; c++) begin
      @(posedge i_clk); #1;
      if (o_out_valid) held_idx = 8'd1;
    end
    chk("no result after abort", {56'd0, held_idx}, 64'd0);
    wait_ready();
    issue(32'd8, lat);
    chk("post-reset latency", 64'(lat), 64'd7);
    chk("post-reset index", {56'd0, o_out_index}, 64'd6);
    chk("post-reset exact", {63'd0, o_out_exact}, 64'd1);
    consume(8'd6, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fib_index.md
FIB_INDEX -- requirements
Module: fib_index

Interface
REQ-001: The block SHALL have parameter WIDTH, default 32, setting the width of the operand searched; legal range 8..64.
REQ-002: The block SHALL have parameter IDXW, default 8, setting the width of the returned index.
REQ-003: CLK  input  1  single clock; all state updates on its rising edge.
REQ-004: RST_X  input  1  reset, asynchronous assert, active-low.
REQ-005: IN_VALID  input  1  IN_VALUE is presented for search.
REQ-006: IN_VALUE  input  WIDTH  unsigned value whose Fibonacci index is requested.
REQ-007: IN_READY  output  1  block accepts a request this cycle; registered.
REQ-008: OUT_VALID  output  1  OUT_INDEX/OUT_EXACT/OUT_OVF are valid; registered.
REQ-009: OUT_READY  input  1  downstream consumes the result.
REQ-010: OUT_INDEX  output  IDXW  largest n with fib(n) <= IN_VALUE.
REQ-011: OUT_EXACT  output  1  fib(OUT_INDEX) == IN_VALUE.
REQ-012: OUT_OVF  output  1  IN_VALUE exceeds the largest fib(n) representable in WIDTH bits.

Function
REQ-013: Sequence definition SHALL be fib(0)=0, fib(1)=fib(2)=1, fib(n)=fib(n-1)+fib(n-2); index returned for value 1 SHALL be 1.
REQ-014: FSM SHALL have states IDLE, SEARCH, DONE; IN_READY=1 only in IDLE, OUT_VALID=1 only in DONE.
REQ-015: IDLE -> SEARCH on edge with IN_VALID && IN_READY (edge E0): latch IN_VALUE into V, load A=0, B=1 (B WIDTH+1 bits), N=0, drop IN_READY.
REQ-016: IN_VALUE SHALL be sampled only at E0; changes afterwards SHALL not affect the result.
REQ-017: Each SEARCH edge, priority order: A==V -> DONE, index N, EXACT=1, OVF=0; A>V -> DONE, index N-1, EXACT=0, OVF=0; A<V and B[WIDTH]==1 -> DONE, index N, EXACT=0, OVF=1; else A<=B[WIDTH-1:0], B<=A+B (WIDTH+1 bit sum), N<=N+1.
REQ-018: Latency: result for decision at N=k SHALL appear (OUT_VALID=1) after edge E0+k+1.
REQ-019: DONE SHALL hold OUT_VALID and all result outputs stable until OUT_VALID && OUT_READY at an edge; then -> IDLE, OUT_VALID<=0, IN_READY<=1 at the same edge.
REQ-020: No bypass: a new request SHALL not be accepted in the cycle a result is consumed.
REQ-021: IN_VALID while not in IDLE SHALL be ignored (no queueing).
REQ-022: N SHALL never exceed IDXW-1 for legal WIDTH; no saturation logic required.
REQ-023: Result outputs SHALL keep their last values after consumption until the next DONE.

Reset
REQ-024: RST_X=0 SHALL immediately force state IDLE, IN_READY=0, OUT_VALID=0, OUT_INDEX=0, OUT_EXACT=0, OUT_OVF=0, A=0, B=1, N=0, V=0, independent of CLK.
REQ-025: IN_READY SHALL rise at the first rising CLK edge with RST_X=1.
REQ-026: Reset asserted during SEARCH or DONE SHALL abort the operation with no result emitted; the pending request is lost.

Verification
REQ-027: IN_VALUE=0 -> OUT_INDEX=0, EXACT=1, OVF=0, OUT_VALID after E0+1.
REQ-028: IN_VALUE=1 -> INDEX=1, EXACT=1 after E0+2; IN_VALUE=4181 -> INDEX=19, EXACT=1 after E0+20.
REQ-029: IN_VALUE=4 -> INDEX=4, EXACT=0, OVF=0 after E0+6; IN_VALUE=2971215073 (WIDTH=32) -> INDEX=47, EXACT=1, OVF=0 after E0+48.
REQ-030: IN_VALUE=0xFFFFFFFF (WIDTH=32) -> INDEX=47, EXACT=0, OVF=1 after E0+48.
REQ-031: OUT_READY held 0 for 10 cycles in DONE -> outputs stable, IN_READY=0 throughout; IN_VALID pulses meanwhile ignored; OUT_READY=1 -> IN_READY=1 next cycle.
REQ-032: RST_X pulsed low at E0+5 of IN_VALUE=4181 search -> all outputs 0 immediately, no OUT_VALID; fresh request IN_VALUE=8 -> INDEX=6, EXACT=1.
